wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the writeback stage merged with the integer register file of the pipelined RV32I core.
- Selects ALU result or memory data. Performs byte/half extraction and sign/zero extension for loads.
- Commits the result to a 32x32 register file that also serves the ID stage's two read ports.
- Keeps a count of committed register writes for performance/debug.

---
 rtl/wb_regfile.sv | 136 +++++++++++++
 tb/tb_wb_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage merged with the integer register file: load extraction/extension, result select,
// 32-entry register file with two read ports and a commit counter. Optional macro: WB_BYPASS_EN.
module wb_regfile #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic                  unsigned_load,
  input  logic [1:0]            LoadSize,
  input  logic [WIDTH-1:0]      data,
  input  logic [WIDTH-1:0]      ALUResult,
  input  logic [ADDR_WIDTH-1:0] Rd,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  output logic [WIDTH-1:0]      WBData,
  output logic                  WBWrite,
  output logic [CNT_WIDTH-1:0]  CommitCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]     regs_r [0:DEPTH-1];
  logic [CNT_WIDTH-1:0] commit_count_r;
  logic [7:0]           byte_sel_s;
  logic [15:0]          half_sel_s;
  logic [WIDTH-1:0]     load_ext_s;
  logic [WIDTH-1:0]     wb_data_s;
  logic                 wb_write_s;
  logic [WIDTH-1:0]     rd1_s;
  logic [WIDTH-1:0]     rd2_s;

  // Sub-word selection from the aligned memory word, then sign/zero extension.
  always_comb begin
    byte_sel_s = 8'h00;
    half_sel_s = 16'h0000;
    load_ext_s = data;
    case (ALUResult[1:0])
      2'b00:   byte_sel_s = data[7:0];
      2'b01:   byte_sel_s = data[15:8];
      2'b10:   byte_sel_s = data[23:16];
      2'b11:   byte_sel_s = data[31:24];
      default: byte_sel_s = data[7:0];
    endcase
    if (ALUResult[1]) begin
      half_sel_s = data[31:16];
    end else begin
      half_sel_s = data[15:0];
    end
    case (LoadSize)
      2'b00: begin
        if (unsigned_load) begin
          load_ext_s = {{(WIDTH-8){1'b0}}, byte_sel_s};
        end else begin
          load_ext_s = {{(WIDTH-8){byte_sel_s[7]}}, byte_sel_s};
        end
      end
      2'b01: begin
        if (unsigned_load) begin
          load_ext_s = {{(WIDTH-16){1'b0}}, half_sel_s};
        end else begin
          load_ext_s = {{(WIDTH-16){half_sel_s[15]}}, half_sel_s};
        end
      end
      default: load_ext_s = data;
    endcase
  end

  // Result select and write qualification; x0 is excluded here so it is never stored.
  always_comb begin
    if (MemtoReg) begin
      wb_data_s = load_ext_s;
    end else begin
      wb_data_s = ALUResult;
    end
    wb_write_s = RegWrite && (Rd != {ADDR_WIDTH{1'b0}});
  end

  // Register array: cleared by reset, written on the rising edge when a commit is qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wb_write_s) begin
      regs_r[Rd] <= wb_data_s;
    end else begin
      regs_r[Rd] <= regs_r[Rd];
    end
  end

  // Commit counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_count_r <= {CNT_WIDTH{1'b0}};
    end else if (wb_write_s) begin
      commit_count_r <= commit_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      commit_count_r <= commit_count_r;
    end
  end

  // Read ports; x0 forced to zero, optional write-through of the committing value.
  always_comb begin
    if (Rs1 == {ADDR_WIDTH{1'b0}}) begin
      rd1_s = {WIDTH{1'b0}};
`ifdef WB_BYPASS_EN
    end else if (wb_write_s && (Rs1 == Rd)) begin
      rd1_s = wb_data_s;
`endif
    end else begin
      rd1_s = regs_r[Rs1];
    end
    if (Rs2 == {ADDR_WIDTH{1'b0}}) begin
      rd2_s = {WIDTH{1'b0}};
`ifdef WB_BYPASS_EN
    end else if (wb_write_s && (Rs2 == Rd)) begin
      rd2_s = wb_data_s;
`endif
    end else begin
      rd2_s = regs_r[Rs2];
    end
  end

  assign ReadData1   = rd1_s;
  assign ReadData2   = rd2_s;
  assign WBData      = wb_data_s;
  assign WBWrite     = wb_write_s;
  assign CommitCount = commit_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table for load extraction, directed corner sequences,
// and randomized traffic against an array-based reference model. Honours WB_BYPASS_EN if defined.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg, unsigned_load;
  logic [1:0]  LoadSize;
  logic [31:0] data, ALUResult;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [31:0] ReadData1, ReadData2, WBData;
  logic        WBWrite;
  logic [31:0] CommitCount;
  logic [31:0] rd1_4, rd2_4, wbd_4;
  logic        wbw_4;
  logic [3:0]  CommitCount4;

  logic [31:0] mregs [32];
  logic [31:0] mcount;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .unsigned_load(unsigned_load), .LoadSize(LoadSize), .data(data), .ALUResult(ALUResult),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WBData(WBData), .WBWrite(WBWrite), .CommitCount(CommitCount)
  );

  wb_regfile #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .unsigned_load(unsigned_load), .LoadSize(LoadSize), .data(data), .ALUResult(ALUResult),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .ReadData1(rd1_4), .ReadData2(rd2_4),
    .WBData(wbd_4), .WBWrite(wbw_4), .CommitCount(CommitCount4)
  );

  typedef struct {
    logic        m2r;
    logic        uns;
    logic [1:0]  ls;
    logic [31:0] d;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Reference writeback value: shift the word down to the selected lane, mask, then extend.
  function automatic logic [31:0] ref_wb(logic m2r, logic uns, logic [1:0] ls,
                                         logic [31:0] d, logic [31:0] alu);
    int unsigned shift, nbits;
    logic [31:0] v, mask;
    if (!m2r) return alu;
    if (ls == 2'b00) begin
      shift = int'(alu[1:0]) * 8;  nbits = 8;
    end else if (ls == 2'b01) begin
      shift = int'(alu[1]) * 16;   nbits = 16;
    end else begin
      return d;
    end
    mask = (32'h1 << nbits) - 32'h1;
    v = (d >> shift) & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (RegWrite && Rd == rs) return ref_wb(MemtoReg, unsigned_load, LoadSize, data, ALUResult);
`endif
    return mregs[rs];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcount = 32'h0;
  endtask

  // One rising edge; the model commits from the inputs as they stand before the edge.
  task automatic commit();
    if (RegWrite && Rd != 5'd0) begin
      mregs[Rd] = ref_wb(MemtoReg, unsigned_load, LoadSize, data, ALUResult);
      mcount = mcount + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RegWrite = 1'b0;
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0; unsigned_load = 1'b0; LoadSize = 2'b10;
    data = 32'h0; ALUResult = 32'h0; Rd = 5'd0; Rs1 = 5'd0; Rs2 = 5'd0;

    vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h80F17F82, 32'h0000_1000, 32'hFFFFFF82};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h80F17F82, 32'h0000_1003, 32'h00000080};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h80F17F82, 32'h0000_1002, 32'hFFFF80F1};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 32'h80F17F82, 32'h0000_1000, 32'h00007F82};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 32'h80F17F82, 32'h0000_1000, 32'h80F17F82};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h80F17F82, 32'h0000_1001, 32'h0000007F};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h80F17F82, 32'h0000_1002, 32'hFFFFFFF1};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 32'h80F17F82, 32'h0000_1003, 32'h000080F1};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 32'h80F17F82, 32'h0000_1001, 32'h00007F82};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 32'h80F17F82, 32'h0000_1003, 32'h80F17F82};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h80F17F82, 32'h1234_5677, 32'h12345677};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 32'hCAFE0001, 32'h0000_0002, 32'hCAFE0001};

    do_reset();
    Rs1 = 5'd5; Rs2 = 5'd31; #1;
    check("reset_rd1", ReadData1, 32'h0);
    check("reset_rd2", ReadData2, 32'h0);
    check("reset_count", CommitCount, 32'h0);

    // Async reset in the middle of a cycle clears stored data immediately.
    RegWrite = 1'b1; MemtoReg = 1'b0; Rd = 5'd5; ALUResult = 32'h1234;
    commit();
    RegWrite = 1'b0; #1;
    check("x5_written", ReadData1, 32'h1234);
    #2;
    rst = 1'b1; #1;
    check("async_rst_rd1", ReadData1, 32'h0);
    check("async_rst_count", CommitCount, 32'h0);
    model_clear();
    #2;
    rst = 1'b0; #1;

    RegWrite = 1'b1; MemtoReg = 1'b0; Rd = 5'd7; ALUResult = 32'hDEADBEEF;
    commit();
    RegWrite = 1'b0; Rs2 = 5'd7; #1;
    check("alu_wb_rd2", ReadData2, 32'hDEADBEEF);
    check("alu_wb_count", CommitCount, 32'd1);

    RegWrite = 1'b1; Rd = 5'd0; ALUResult = 32'hFFFFFFFF; #1;
    check("x0_wbwrite", {31'h0, WBWrite}, 32'h0);
    commit();
    RegWrite = 1'b0; Rs1 = 5'd0; #1;
    check("x0_rd1", ReadData1, 32'h0);
    check("x0_count", CommitCount, 32'd1);

    RegWrite = 1'b1; Rd = 5'd9; ALUResult = 32'h11111111;
    commit();
    Rs1 = 5'd9; ALUResult = 32'hA5A5A5A5; #1;
`ifdef WB_BYPASS_EN
    check("same_cycle_before", ReadData1, 32'hA5A5A5A5);
`else
    check("same_cycle_before", ReadData1, 32'h11111111);
`endif
    commit();
    RegWrite = 1'b0; #1;
    check("same_cycle_after", ReadData1, 32'hA5A5A5A5);

    for (int i = 0; i < 12; i++) begin
      RegWrite = 1'b1; Rd = 5'd20; Rs1 = 5'd3;
      MemtoReg = vecs[i].m2r; unsigned_load = vecs[i].uns; LoadSize = vecs[i].ls;
      data = vecs[i].d; ALUResult = vecs[i].alu; #1;
      check($sformatf("vec%0d_wbdata", i), WBData, vecs[i].exp);
      commit();
      RegWrite = 1'b0; Rs1 = 5'd20; #1;
      check($sformatf("vec%0d_stored", i), ReadData1, vecs[i].exp);
    end

    for (int n = 0; n < 400; n++) begin
      RegWrite = 1'($urandom_range(0, 1)); MemtoReg = 1'($urandom_range(0, 1));
      unsigned_load = 1'($urandom_range(0, 1)); LoadSize = 2'($urandom_range(0, 3));
      data = $urandom; ALUResult = $urandom;
      Rd = 5'($urandom_range(0, 31));
      Rs1 = ($urandom_range(0, 3) == 0) ? Rd : 5'($urandom_range(0, 31));
      Rs2 = ($urandom_range(0, 3) == 0) ? Rd : 5'($urandom_range(0, 31));
      #1;
      check("rnd_wbdata", WBData, ref_wb(MemtoReg, unsigned_load, LoadSize, data, ALUResult));
      check("rnd_wbwrite", {31'h0, WBWrite}, {31'h0, (RegWrite && Rd != 5'd0)});
      check("rnd_rd1", ReadData1, ref_read(Rs1));
      check("rnd_rd2", ReadData2, ref_read(Rs2));
      commit();
      check("rnd_count", CommitCount, mcount);
    end

    // Narrow counter wraps after 16 commits.
    do_reset();
    MemtoReg = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      RegWrite = 1'b1; Rd = 5'((k % 31) + 1); ALUResult = k;
      commit();
      if (k == 15) check("wrap_15", {28'h0, CommitCount4}, 32'hF);
      if (k == 16) check("wrap_16", {28'h0, CommitCount4}, 32'h0);
      if (k == 17) check("wrap_17", {28'h0, CommitCount4}, 32'h1);
    end
    RegWrite = 1'b0; #1;
    check("wide_count_17", CommitCount, 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
